qpu_itcm_mport_ctrl: RTL and testbench



---
 rtl/qpu_itcm_mport_ctrl_pkg.sv | 25 ++
 rtl/qpu_itcm_rsp_fifo.sv | 68 ++++++
 rtl/qpu_itcm_mport_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_qpu_itcm_mport_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_itcm_mport_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | qpu_itcm_mport_ctrl_pkg : shared ITCM widths, latency and helpers        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package qpu_itcm_mport_ctrl_pkg;

  localparam int QPU_ITCM_ADDR_WIDTH = 16;
  localparam int QPU_ITCM_DATA_WIDTH = 64;
  localparam int QPU_ITCM_WMSK_WIDTH = QPU_ITCM_DATA_WIDTH / 8;
  localparam int QPU_ITCM_AW_LSB     = 3;
  localparam int QPU_ITCM_RAM_AW     = QPU_ITCM_ADDR_WIDTH - QPU_ITCM_AW_LSB;
  localparam int QPU_ITCM_RD_LAT     = 1;
  localparam int QPU_ITCM_NPORTS     = 2;
  localparam int QPU_ITCM_BUF_DEPTH  = 4;

  // Port-ID field never collapses to zero bits, even for a single initiator.
  function automatic int pid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qpu_itcm_rsp_fifo.sv
// +--------------------------------------------------------------------------+
// | qpu_itcm_rsp_fifo : sync response FIFO, fall-through when empty          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module qpu_itcm_rsp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_empty, w_full, w_enq, w_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty = (cnt_q == '0);
  assign w_full  = (cnt_q == CNT_W'(DEPTH));
  // An entry pushed into an empty FIFO and popped in the same cycle is never stored.
  assign w_enq   = push_i & ~(w_empty & pop_i);
  assign w_deq   = pop_i & ~w_empty;

  assign out_valid_o = ~w_empty | push_i;
  assign out_data_o  = w_empty ? push_data_i : mem_q[rd_q];
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign count_o     = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_enq) wr_q <= ptr_inc(wr_q);
      if (w_deq) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) mem_q[wr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && w_full && !pop_i));

endmodule

`default_nettype wire

// File: rtl/qpu_itcm_mport_ctrl.sv
// +--------------------------------------------------------------------------+
// | qpu_itcm_mport_ctrl : round-robin multi-port ICB access to one ITCM SRAM |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module qpu_itcm_mport_ctrl
  import qpu_itcm_mport_ctrl_pkg::*;
#(
  parameter int N_PORTS   = QPU_ITCM_NPORTS,
  parameter int AW        = QPU_ITCM_ADDR_WIDTH,
  parameter int DW        = QPU_ITCM_DATA_WIDTH,
  parameter int MW        = QPU_ITCM_WMSK_WIDTH,
  parameter int AW_LSB    = QPU_ITCM_AW_LSB,
  parameter int RAM_AW    = QPU_ITCM_RAM_AW,
  parameter int RD_LAT    = QPU_ITCM_RD_LAT,
  parameter int BUF_DEPTH = QPU_ITCM_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  itcm_active,
  input  logic [N_PORTS-1:0]    i_icb_cmd_valid,
  output logic [N_PORTS-1:0]    i_icb_cmd_ready,
  input  logic [N_PORTS-1:0]    i_icb_cmd_read,
  input  logic [N_PORTS*AW-1:0] i_icb_cmd_addr,
  input  logic [N_PORTS*DW-1:0] i_icb_cmd_wdata,
  input  logic [N_PORTS*MW-1:0] i_icb_cmd_wmask,
  output logic [N_PORTS-1:0]    i_icb_rsp_valid,
  input  logic [N_PORTS-1:0]    i_icb_rsp_ready,
  output logic [DW-1:0]         i_icb_rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [MW-1:0]         ram_wem,
  output logic [DW-1:0]         ram_din,
  input  logic [DW-1:0]         ram_dout
);

  localparam int PID_W = pid_width(N_PORTS);
  localparam int CRD_W = $clog2(BUF_DEPTH + 1);
  localparam int FW    = DW + PID_W;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [PID_W-1:0]   rr_q, rr_d;
  logic [CRD_W-1:0]   credit_q, credit_d;

  logic [N_PORTS-1:0] w_grant;
  logic [PID_W-1:0]   w_gidx;
  logic               w_gvld, w_credit_ok, w_issue, w_pop;
  logic               w_sel_read;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_wdata;
  logic [MW-1:0]      w_sel_wmask;

  logic [RD_LAT-1:0]  pvld_q, prd_q;
  logic [PID_W-1:0]   ppid_q [RD_LAT];

  logic               w_push, w_fvld, w_fifo_full, w_fifo_empty;
  logic [FW-1:0]      w_push_data, w_fout;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic [PID_W-1:0]   w_head_pid;
  logic               w_unused_bits;

  // Round-robin: first valid port at or above rr_q, otherwise the lowest valid port.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_gvld  = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!w_gvld && i_icb_cmd_valid[k] && (PID_W'(k) >= rr_q)) begin
        w_grant[k] = 1'b1;
        w_gidx     = PID_W'(k);
        w_gvld     = 1'b1;
      end
    end
    for (int k = 0; k < N_PORTS; k++) begin
      if (!w_gvld && i_icb_cmd_valid[k]) begin
        w_grant[k] = 1'b1;
        w_gidx     = PID_W'(k);
        w_gvld     = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_read  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wmask = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (w_grant[k]) begin
        w_sel_read  = i_icb_cmd_read[k];
        w_sel_addr  = i_icb_cmd_addr[k*AW +: AW];
        w_sel_wdata = i_icb_cmd_wdata[k*DW +: DW];
        w_sel_wmask = i_icb_cmd_wmask[k*MW +: MW];
      end
    end
  end

  assign w_credit_ok     = (credit_q != '0);
  assign w_issue         = w_gvld & w_credit_ok & ~rst;
  assign i_icb_cmd_ready = w_grant & {N_PORTS{w_credit_ok & ~rst}};

  always_comb begin
    ram_cs   = w_issue;
    ram_we   = w_issue & ~w_sel_read;
    ram_addr = w_issue ? w_sel_addr[AW_LSB +: RAM_AW] : '0;
    ram_wem  = (w_issue & ~w_sel_read) ? w_sel_wmask : '0;
    ram_din  = w_issue ? w_sel_wdata : '0;
  end

  always_comb begin
    rr_d = rr_q;
    if (w_issue) begin
      rr_d = (w_gidx == PID_W'(N_PORTS - 1)) ? '0 : w_gidx + PID_W'(1);
    end
  end

  always_comb begin
    credit_d = credit_q;
    case ({w_issue, w_pop})
      2'b10:   credit_d = credit_q - CRD_W'(1);
      2'b01:   credit_d = credit_q + CRD_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      credit_q <= CRD_W'(BUF_DEPTH);
    end else begin
      rr_q     <= rr_d;
      credit_q <= credit_d;
    end
  end

  // Tag pipe tracks {port, is_read} alongside the SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pvld_q <= '0;
      prd_q  <= '0;
      for (int s = 0; s < RD_LAT; s++) ppid_q[s] <= '0;
    end else begin
      pvld_q[0] <= w_issue;
      prd_q[0]  <= w_sel_read;
      ppid_q[0] <= w_gidx;
      for (int s = 1; s < RD_LAT; s++) begin
        pvld_q[s] <= pvld_q[s-1];
        prd_q[s]  <= prd_q[s-1];
        ppid_q[s] <= ppid_q[s-1];
      end
    end
  end

  assign w_push      = pvld_q[RD_LAT-1];
  assign w_push_data = {ppid_q[RD_LAT-1], (prd_q[RD_LAT-1] ? ram_dout : {DW{1'b0}})};

  qpu_itcm_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .out_valid_o (w_fvld),
    .out_data_o  (w_fout),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (w_fifo_cnt)
  );

  assign w_head_pid      = w_fout[DW +: PID_W];
  assign i_icb_rsp_rdata = w_fout[DW-1:0];

  always_comb begin
    i_icb_rsp_valid = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (w_fvld && !rst && (w_head_pid == PID_W'(k))) i_icb_rsp_valid[k] = 1'b1;
    end
  end

  assign w_pop       = |(i_icb_rsp_valid & i_icb_rsp_ready);
  assign itcm_active = (|i_icb_cmd_valid) | (|pvld_q) | ~w_fifo_empty;

  assign w_unused_bits = ^{w_sel_addr, w_fifo_full, w_fifo_cnt};

endmodule

`default_nettype wire

// File: tb/tb_qpu_itcm_mport_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_qpu_itcm_mport_ctrl : directed bench, RD_LAT=1 and RD_LAT=2 instances |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_qpu_itcm_mport_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd_valid = '0, cmd_read = '0, rsp_ready = '0;
  logic [31:0] cmd_addr = '0;
  logic [127:0] cmd_wdata = '0;
  logic [15:0] cmd_wmask = '0;

  logic        a_active, b_active;
  logic [1:0]  a_cmd_ready, b_cmd_ready, a_rsp_valid, b_rsp_valid;
  logic [63:0] a_rdata, b_rdata, a_din, b_din, a_dout, b_dout, b_p1;
  logic        a_cs, b_cs, a_we, b_we;
  logic [12:0] a_addr, b_addr;
  logic [7:0]  a_wem, b_wem;

  logic [63:0] mem_a [0:31];
  logic [63:0] mem_b [0:31];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qpu_itcm_mport_ctrl #(.N_PORTS(2), .RD_LAT(1), .BUF_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .itcm_active(a_active),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(a_cmd_ready), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(a_rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(a_rdata),
    .ram_cs(a_cs), .ram_we(a_we), .ram_addr(a_addr), .ram_wem(a_wem), .ram_din(a_din),
    .ram_dout(a_dout));

  qpu_itcm_mport_ctrl #(.N_PORTS(2), .RD_LAT(2), .BUF_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .itcm_active(b_active),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(b_cmd_ready), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(b_rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(b_rdata),
    .ram_cs(b_cs), .ram_we(b_we), .ram_addr(b_addr), .ram_wem(b_wem), .ram_din(b_din),
    .ram_dout(b_dout));

  // Initial SRAM contents.
  function automatic logic [63:0] bg(input int w);
    if (w == 1) return 64'hDEADBEEF_00000001;
    if (w >= 3 && w < 32) return {32'hCAFE0000, 32'(w)};
    return 64'h0;
  endfunction

  // SRAM models: one-cycle and two-cycle read latency.
  always @(posedge clk) begin
    if (a_cs && a_we) begin
      for (int b = 0; b < 8; b++) if (a_wem[b]) mem_a[a_addr[4:0]][b*8 +: 8] = a_din[b*8 +: 8];
    end
    if (a_cs && !a_we) a_dout <= mem_a[a_addr[4:0]];
  end

  always @(posedge clk) begin
    if (b_cs && b_we) begin
      for (int b = 0; b < 8; b++) if (b_wem[b]) mem_b[b_addr[4:0]][b*8 +: 8] = b_din[b*8 +: 8];
    end
    if (b_cs && !b_we) b_p1 <= mem_b[b_addr[4:0]];
    b_dout <= b_p1;
  end

  task automatic set_port(input int p, input logic rd, input logic [15:0] a,
                          input logic [63:0] wd, input logic [7:0] wm);
    cmd_read[p]          = rd;
    cmd_addr[p*16 +: 16] = a;
    cmd_wdata[p*64 +: 64] = wd;
    cmd_wmask[p*8 +: 8]  = wm;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1; cmd_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 2'b01; set_port(0, 1'b1, 16'h0008, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (a_cmd_ready !== 2'b00) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 00", a_cmd_ready); end
    n_cmp++; if (a_cs !== 1'b0 || a_addr !== 13'd0) begin n_err++; $display("FAIL reset_ram: got cs=%b addr=%h want 0/0", a_cs, a_addr); end
    n_cmp++; if (a_rsp_valid !== 2'b00 || b_rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b/%b want 00", a_rsp_valid, b_rsp_valid); end
    rst = 1'b0; cmd_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (a_active !== 1'b0 || b_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b/%b want 0", a_active, b_active); end
  endtask

  task automatic test_single_read;
    @(negedge clk);
    rsp_ready = 2'b11; cmd_valid = 2'b01; set_port(0, 1'b1, 16'h0008, '0, '0); #1;
    n_cmp++; if (a_cmd_ready !== 2'b01) begin n_err++; $display("FAIL rd_cmd_ready: got %b want 01", a_cmd_ready); end
    n_cmp++; if (a_cs !== 1'b1 || a_we !== 1'b0 || a_addr !== 13'd1 || a_wem !== 8'h00) begin
      n_err++; $display("FAIL rd_ram_ctl: got cs=%b we=%b addr=%h wem=%h want 1/0/1/00", a_cs, a_we, a_addr, a_wem); end
    @(negedge clk);
    cmd_valid = 2'b00; #1;
    n_cmp++; if (a_rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 01", a_rsp_valid); end
    n_cmp++; if (a_rdata !== 64'hDEADBEEF_00000001) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef00000001", a_rdata); end
    @(negedge clk); #1;
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_rsp_drop: got %b want 00", a_rsp_valid); end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    cmd_valid = 2'b10; set_port(1, 1'b0, 16'h0010, 64'h11223344_55667788, 8'h0F); #1;
    n_cmp++; if (a_cmd_ready !== 2'b10) begin n_err++; $display("FAIL wr_cmd_ready: got %b want 10", a_cmd_ready); end
    n_cmp++; if (a_we !== 1'b1 || a_wem !== 8'h0F || a_addr !== 13'd2 || a_din !== 64'h11223344_55667788) begin
      n_err++; $display("FAIL wr_ram_ctl: got we=%b wem=%h addr=%h din=%h", a_we, a_wem, a_addr, a_din); end
    @(negedge clk);
    set_port(1, 1'b1, 16'h0010, '0, '0); #1;
    n_cmp++; if (a_rsp_valid !== 2'b10 || a_rdata !== 64'h0) begin
      n_err++; $display("FAIL wr_rsp: got valid=%b rdata=%h want 10/0", a_rsp_valid, a_rdata); end
    @(negedge clk);
    cmd_valid = 2'b00; #1;
    n_cmp++; if (a_rsp_valid !== 2'b10 || a_rdata !== 64'h00000000_55667788) begin
      n_err++; $display("FAIL wr_readback: got valid=%b rdata=%h want 10/0000000055667788", a_rsp_valid, a_rdata); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_contention;
    logic [1:0] exp;
    exp = 2'b01;
    set_port(0, 1'b1, 16'h00A0, '0, '0);
    set_port(1, 1'b1, 16'h00A8, '0, '0);
    rsp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cmd_valid = 2'b11; #1;
      n_cmp++; if (a_cmd_ready !== exp) begin n_err++; $display("FAIL contend_grant[%0d]: got %b want %b", c, a_cmd_ready, exp); end
      exp = {exp[0], exp[1]};
    end
    @(negedge clk);
    cmd_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int issued, got;
    issued = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      cmd_valid = (issued < 6) ? 2'b01 : 2'b00;
      set_port(0, 1'b1, 16'((8 + issued) * 8), '0, '0);
      rsp_ready = (cyc >= 8) ? 2'b01 : 2'b00;
      #1;
      if (cyc == 7) begin
        n_cmp++; if (issued != 4) begin n_err++; $display("FAIL bp_issued: got %0d want 4", issued); end
        n_cmp++; if (a_cmd_ready !== 2'b00) begin n_err++; $display("FAIL bp_stall: got %b want 00", a_cmd_ready); end
        n_cmp++; if (a_rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_head: got %b want 01", a_rsp_valid); end
      end
      if (a_rsp_valid[1] !== 1'b0) begin n_cmp++; n_err++; $display("FAIL bp_port1_rsp: got %b want 0", a_rsp_valid[1]); end
      if (a_rsp_valid[0] && rsp_ready[0]) begin
        n_cmp++; if (a_rdata !== bg(8 + got)) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", got, a_rdata, bg(8 + got)); end
        got++;
      end
      if (cmd_valid[0] && a_cmd_ready[0]) issued++;
    end
    n_cmp++; if (got != 6 || issued != 6) begin n_err++; $display("FAIL bp_done: got %0d rsp %0d cmd want 6/6", got, issued); end
    @(negedge clk);
    cmd_valid = 2'b00; rsp_ready = 2'b11;
  endtask

  task automatic test_rdlat2;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cmd_valid = (c < 3) ? 2'b01 : 2'b00;
      set_port(0, 1'b1, 16'((3 + c) * 8), '0, '0);
      rsp_ready = 2'b11; #1;
      if (c < 3) begin
        n_cmp++; if (b_cmd_ready !== 2'b01) begin n_err++; $display("FAIL lat2_cmd_ready[%0d]: got %b want 01", c, b_cmd_ready); end
      end
      n_cmp++; if (b_rsp_valid !== ((c >= 2 && c <= 4) ? 2'b01 : 2'b00)) begin
        n_err++; $display("FAIL lat2_rsp_valid[%0d]: got %b", c, b_rsp_valid); end
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (b_rdata !== bg(c + 1)) begin n_err++; $display("FAIL lat2_rdata[%0d]: got %h want %h", c, b_rdata, bg(c + 1)); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    int ha, hb;
    ha = 0; hb = 0;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmd_valid = 2'b01; rsp_ready = 2'b00; set_port(0, 1'b1, 16'((10 + c) * 8), '0, '0); #1;
      n_cmp++; if (a_cmd_ready !== 2'b01) begin n_err++; $display("FAIL mid_issue[%0d]: got %b want 01", c, a_cmd_ready); end
    end
    @(negedge clk);
    cmd_valid = 2'b00; #1;
    n_cmp++; if (a_active !== 1'b1) begin n_err++; $display("FAIL mid_active_before: got %b want 1", a_active); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    n_cmp++; if (a_rsp_valid !== 2'b00 || b_rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_cleared: got %b/%b want 00", a_rsp_valid, b_rsp_valid); end
    n_cmp++; if (a_active !== 1'b0 || b_active !== 1'b0) begin n_err++; $display("FAIL mid_active_after: got %b/%b want 0", a_active, b_active); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cmd_valid = 2'b01; #1;
      if (a_cmd_ready[0]) ha++;
      if (b_cmd_ready[0]) hb++;
    end
    n_cmp++; if (ha != 4 || hb != 4) begin n_err++; $display("FAIL mid_credit: got %0d/%0d handshakes want 4/4", ha, hb); end
    @(negedge clk);
    cmd_valid = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = bg(i);
      mem_b[i] = bg(i);
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_backpressure();
    test_rdlat2();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
